// File: rtl/ecc_pkg.sv
// Shared ECC field helpers: default prime, slope-stage state encoding and
// 65-bit conditional-correct modular add/sub.
package ecc_pkg;

    localparam logic [63:0] P_DEFAULT = 64'hFFFF_FFFF_FFFF_FFC5;

    typedef enum logic [2:0] {
        StIdle,
        StSub,
        StInvReq,
        StInvWait,
        StMul,
        StDone
    } slope_state_e;

    // Operands must already be reduced below p.
    function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] p);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) begin
            s = s - {1'b0, p};
        end
        return s[63:0];
    endfunction

    function automatic logic [63:0] mod_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] p);
        logic [64:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            d = d + {1'b0, p};
        end
        return d[63:0];
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// 64-cycle MSB-first interleaved modular multiplier: product = a * b mod P.
// The first iteration (bit 63) happens on the accepting edge; done pulses with the final product.
module mod_mul_serial
    import ecc_pkg::*;
#(
    parameter logic [63:0] P = P_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic        run_q;
    logic        done_q;
    logic [5:0]  cnt_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [63:0] acc_q;

    logic        accept;
    logic        bit_sel;
    logic [63:0] acc_src;
    logic [63:0] addend;
    logic [63:0] acc_dbl;
    logic [63:0] acc_nxt;

    assign accept = go & ~run_q;

    // Accepting edge works straight off the input operands with a cleared accumulator.
    always_comb begin
        acc_src = accept ? 64'd0 : acc_q;
        addend  = accept ? a : a_q;
        bit_sel = accept ? b[63] : b_q[cnt_q];
        acc_dbl = mod_add(acc_src, acc_src, P);
        acc_nxt = bit_sel ? mod_add(acc_dbl, addend, P) : acc_dbl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 6'd0;
            a_q    <= 64'd0;
            b_q    <= 64'd0;
            acc_q  <= 64'd0;
        end else begin
            done_q <= run_q && (cnt_q == 6'd0);
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                acc_q <= acc_nxt;
                cnt_q <= 6'd62;
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    run_q <= 1'b0;
                end
            end
        end
    end

    assign busy    = run_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/ecc_slope_calc.sv
// Point-add slope lambda = (y2 - y1) / (x2 - x1) mod P around an external ALU_INV.
// Optional inverter watchdog enabled by defining ECC_SLOPE_TIMEOUT_EN.
module ecc_slope_calc
    import ecc_pkg::*;
#(
    parameter logic [63:0] P       = P_DEFAULT,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] x1,
    input  logic [63:0] y1,
    input  logic [63:0] x2,
    input  logic [63:0] y2,
    output logic        inv_enable,
    output logic [63:0] inv_t,
    input  logic [63:0] inv_result,
    input  logic        inv_done,
    output logic [63:0] lambda,
    output logic        done,
    output logic        busy,
    output logic        err
);

    slope_state_e state_q, state_d;

    logic [63:0] x1_q, y1_q, x2_q, y2_q;
    logic [63:0] num_q;
    logic [63:0] inv_t_q;
    logic [63:0] lambda_q;
    logic        err_q;

    logic [63:0] num_c;
    logic [63:0] den_c;
    logic        mul_go;
    logic        mul_done;
    logic [63:0] mul_product;
    logic        unused_mul_busy;

    assign num_c = mod_sub(y2_q, y1_q, P);
    assign den_c = mod_sub(x2_q, x1_q, P);

`ifdef ECC_SLOPE_TIMEOUT_EN
    localparam logic [12:0] TmoLast = 13'(TIMEOUT - 1);

    logic [12:0] tmo_cnt_q;
    logic        tmo_hit;

    assign tmo_hit = (state_q == StInvWait) && !inv_done && (tmo_cnt_q == TmoLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 13'd0;
        end else if (state_q == StInvReq) begin
            tmo_cnt_q <= 13'd0;
        end else if (state_q == StInvWait) begin
            tmo_cnt_q <= tmo_cnt_q + 13'd1;
        end
    end
`else
    logic tmo_hit;
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        mul_go  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSub;
                end
            end
            StSub: begin
                state_d = (den_c == 64'd0) ? StDone : StInvReq;
            end
            StInvReq: begin
                state_d = StInvWait;
            end
            StInvWait: begin
                if (inv_done) begin
                    mul_go  = 1'b1;
                    state_d = StMul;
                end else if (tmo_hit) begin
                    state_d = StDone;
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q     <= 64'd0;
            y1_q     <= 64'd0;
            x2_q     <= 64'd0;
            y2_q     <= 64'd0;
            num_q    <= 64'd0;
            inv_t_q  <= 64'd0;
            lambda_q <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                x1_q <= x1;
                y1_q <= y1;
                x2_q <= x2;
                y2_q <= y2;
            end
            if (state_q == StSub) begin
                num_q   <= num_c;
                inv_t_q <= den_c;
                // Vertical line: no finite slope, skip the inverter entirely.
                if (den_c == 64'd0) begin
                    lambda_q <= 64'd0;
                    err_q    <= 1'b1;
                end
            end
            if (state_q == StMul && mul_done) begin
                lambda_q <= mul_product;
                err_q    <= 1'b0;
            end
            if (tmo_hit) begin
                lambda_q <= 64'd0;
                err_q    <= 1'b1;
            end
        end
    end

    mod_mul_serial #(
        .P(P)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (mul_go),
        .a      (num_q),
        .b      (inv_result),
        .busy   (unused_mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    assign inv_enable = (state_q == StInvReq);
    assign inv_t      = inv_t_q;
    assign lambda     = lambda_q;
    assign err        = err_q;
    assign done       = (state_q == StDone);
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/ecc_slope_calc.md
Name: ecc_slope_calc

Overview:
- Computes the point-addition slope lambda = (y2 - y1) * (x2 - x1)^-1 mod P for the ECC datapath.
- Sits directly upstream and downstream of ALU_INV:
  - forms the denominator and issues it to the inverter with a one-cycle enable pulse;
  - waits for inv_done;
  - multiplies the returned inverse by the numerator with a 64-cycle serial modular multiplier.
- Its output feeds the point-add x3/y3 stage.

Parameters:
- P, 64'hFFFFFFFFFFFFFFC5, field prime. Must match the modulus hard-wired in ALU_INV.
- TIMEOUT, 4096, inverter watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x1, y1, x2, y2  in  64 each  affine coordinates; caller guarantees each < P; lambda is unspecified otherwise
- inv_enable  out  1  one-cycle pulse to ALU_INV.enable
- inv_t  out  64  denominator to ALU_INV.t; held stable from the pulse until inv_done
- inv_result  in  64  from ALU_INV.result
- inv_done  in  1  from ALU_INV.inv_done
- lambda  out  64  slope result; held until the next start is accepted
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE
- err  out  1  valid with done; 1 = degenerate or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE. lambda, inv_t, internal registers = 0. inv_enable, done, busy, err = 0. Reset mid-operation aborts immediately with no output pulse. ALU_INV shares rst_n.
- IDLE -> SUB on start=1. Latch x1..y2 in the same edge. start in any other state is ignored, not queued.
- SUB (1 cycle): num = y2 - y1 mod P, den = x2 - x1 mod P. Rule: if a >= b then a - b, else a - b + P, computed in 65 bits.
  - den == 0 -> DONE with err=1, lambda=0. The inverter is never enabled.
  - Otherwise -> INV_REQ.
- INV_REQ (1 cycle): inv_enable=1, inv_t=den -> INV_WAIT.
- INV_WAIT: on inv_done=1, latch inv_result as b_reg, clear acc -> MUL. inv_done in any other state is ignored.
- MUL (exactly 64 cycles, bit i = 63 down to 0):
  - acc <- 2*acc mod P, then + num mod P if b_reg[i].
  - Both conditional subtracts are chained in one cycle, with 65-bit intermediates.
  - 6-bit counter; after i=0 -> DONE.
- DONE (1 cycle): done=1, lambda=acc (or 0 on error), err set accordingly -> IDLE. busy drops in the IDLE cycle that follows.
- Latency:
  - If inv_done is sampled at edge k, done is high in cycle k+65.
  - Degenerate case: done is high 2 cycles after start is accepted.
- Back-to-back: start is accepted in the first IDLE cycle after done.

Optional Feature:
- Macro ECC_SLOPE_TIMEOUT_EN.
- Defined:
  - a 13-bit counter runs in INV_WAIT;
  - if TIMEOUT cycles elapse without inv_done -> DONE with err=1, lambda=0;
  - a late inv_done arriving afterwards is ignored.
- Undefined: INV_WAIT waits indefinitely, and TIMEOUT is unused.

Decomposition:
- Shared package ecc_pkg holds:
  - prime constant P_DEFAULT;
  - state encoding (IDLE, SUB, INV_REQ, INV_WAIT, MUL, DONE);
  - functions mod_add and mod_sub (65-bit conditional correct).
- Natural sub-module: mod_mul_serial, the 64-cycle MSB-first interleaved multiplier.
  - Interface: clk, rst_n, go, a, b, busy, done, product.
  - It is reused later by the point-add stage.

Test Plan:
- x1=1, y1=5, x2=3, y2=19, with the real ALU_INV -> inv_t=2, one inv_enable pulse, lambda=7, err=0, done exactly 65 cycles after inv_done.
- Wrap-around: x1=3, y1=19, x2=1, y2=5 -> inv_t=P-2 (64'hFFFFFFFFFFFFFFC3), lambda=7.
- x1=0, y1=0, x2=1, y2=P-1 -> inv_t=1, lambda=64'hFFFFFFFFFFFFFFC4.
- Degenerate x1=x2=10 -> inv_enable never asserted, done 2 cycles after start, err=1, lambda=0.
- Pulse start again during MUL with different operands -> ignored; first result unchanged. Then assert rst_n=0 during INV_WAIT -> all outputs 0, state IDLE, no done pulse.
- With ECC_SLOPE_TIMEOUT_EN and TIMEOUT=16, using a stub that never asserts inv_done -> done at INV_WAIT entry+16 with err=1, lambda=0. A later inv_done pulse produces no second done.
